// File: rtl/freq_gen.sv
// ---------------------------------------------------------------------------
// freq_gen
//
// Programmable square-wave frequency generator. A target frequency in Hz is
// accepted over a valid/ready handshake, converted to a half-period count
// N = floor(CLK_FS / (2*f)) by a bit-serial restoring divider, and then
// switched into the output divider only at a rising-edge boundary so that
// clk_out never carries a truncated phase.
//
// Ports:
//   sys_clk    reference clock, the only clock domain
//   sys_rst    synchronous active-high reset
//   freq_set   requested output frequency in Hz
//   set_valid  freq_set is valid, held until accepted
//   set_ready  block can accept a new setting (high only while idle)
//   clk_out    generated square wave, period 2*N sys_clk cycles
//   freq_act   frequency currently applied, after clamping
//   range_err  one-cycle pulse when a request was clamped to CLK_FS/2
// ---------------------------------------------------------------------------
module freq_gen #(
  parameter int unsigned CLK_FS = 50_000_000,
  parameter int unsigned FREQ_W = 20,
  parameter int unsigned DIV_W  = 26
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [FREQ_W-1:0] freq_set,
  input  logic              set_valid,
  output logic              set_ready,
  output logic              clk_out,
  output logic [FREQ_W-1:0] freq_act,
  output logic              range_err
);

  localparam int unsigned FS_HALF  = CLK_FS / 2;
  localparam int unsigned BC_W     = $clog2(DIV_W + 1);
  localparam int unsigned REM_W    = FREQ_W + 1;
  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_FS);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DIV_W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    APPLY
  } state_t;

  state_t state, state_next;

  logic              xfer;
  logic              req_clamp;
  logic              req_zero;
  logic [FREQ_W-1:0] req_f;

  logic [FREQ_W-1:0] f_req;
  logic [FREQ_W:0]   divisor;
  logic [REM_W-1:0]  rem;
  logic [REM_W:0]    trial;
  logic [REM_W-1:0]  trial_sub;
  logic              trial_ge;
  logic [DIV_W-1:0]  quo;
  logic [DIV_W-1:0]  dvd_sh;
  logic [BC_W-1:0]   bit_cnt;
  logic              calc_done;
  logic [DIV_W-1:0]  n_pend;

  logic [DIV_W-1:0]  n_cur;
  logic [DIV_W-1:0]  cnt;
  logic              at_rise;
  logic              boundary;

  // Request decoding: requests above half the reference rate are clamped,
  // and zero means stop. The comparison is widened so that it stays correct
  // whether or not CLK_FS/2 is representable in FREQ_W bits.
  always_comb begin
    req_clamp = 64'(freq_set) > 64'(FS_HALF);
    req_zero  = (freq_set == '0);
    req_f     = req_clamp ? FREQ_W'(FS_HALF) : freq_set;
  end

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and subtract the divisor if it fits. The remainder is
  // always below the divisor, so the subtraction result fits in REM_W bits.
  always_comb begin
    trial     = {rem, dvd_sh[DIV_W-1]};
    trial_ge  = (trial >= {1'b0, divisor});
    trial_sub = trial[REM_W-1:0] - divisor;
    calc_done = (bit_cnt == BC_LAST);
  end

  // A switch point is the cycle where the running generator would drive
  // clk_out from 0 to 1, i.e. just after a complete low phase. A stopped
  // generator can be switched at any time.
  always_comb begin
    at_rise  = (n_cur != '0) && !clk_out && (cnt == n_cur - DIV_W'(1));
    boundary = (n_cur == '0) || at_rise;
  end

  // Control state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake logic. A stop request needs no division and
  // goes straight to waiting for the switch point.
  always_comb begin
    state_next = state;
    set_ready  = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        set_ready = 1'b1;
        xfer      = set_valid;
        if (set_valid) begin
          state_next = req_zero ? APPLY : CALC;
        end
      end
      CALC: begin
        if (calc_done) begin
          state_next = APPLY;
        end
      end
      APPLY: begin
        if (boundary) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture and the bit-serial divider. The quotient is built MSB
  // first over DIV_W iterations; the cycle after the last iteration copies it
  // into the pending half-period register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      f_req     <= '0;
      divisor   <= '0;
      rem       <= '0;
      quo       <= '0;
      dvd_sh    <= '0;
      bit_cnt   <= '0;
      n_pend    <= '0;
      range_err <= 1'b0;
    end else begin
      range_err <= 1'b0;
      if (xfer) begin
        f_req     <= req_f;
        divisor   <= {req_f, 1'b0};
        rem       <= '0;
        quo       <= '0;
        dvd_sh    <= DIVIDEND;
        bit_cnt   <= '0;
        n_pend    <= '0;
        range_err <= req_clamp;
      end else if (state == CALC) begin
        if (!calc_done) begin
          rem     <= trial_ge ? trial_sub : trial[REM_W-1:0];
          quo     <= {quo[DIV_W-2:0], trial_ge};
          dvd_sh  <= {dvd_sh[DIV_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BC_W'(1);
        end else begin
          n_pend <= quo;
        end
      end
    end
  end

  // Output divider. At the switch point the new half-period is loaded and
  // the rising edge the old setting was about to make is produced (or
  // suppressed when stopping), so every phase lasts a full N.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      n_cur    <= '0;
      cnt      <= '0;
      clk_out  <= 1'b0;
      freq_act <= '0;
    end else if ((state == APPLY) && boundary) begin
      n_cur    <= n_pend;
      cnt      <= '0;
      freq_act <= f_req;
      clk_out  <= (n_pend != '0);
    end else if (n_cur == '0) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (cnt == n_cur - DIV_W'(1)) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_freq_gen.sv
// ---------------------------------------------------------------------------
// tb_freq_gen
//
// Self-checking bench for freq_gen. The reference rate is scaled down to
// 2 MHz so that the whole 20-bit request range reaches past CLK_FS/2 and
// the clamp path is reachable, and so that half-periods stay short.
// Expected half-periods come from plain arithmetic on the requested
// frequency; clk_out is judged by the lengths of its high and low runs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_freq_gen;

  localparam int unsigned CLK_FS  = 2_000_000;
  localparam int unsigned FREQ_W  = 20;
  localparam int unsigned DIV_W   = 26;
  localparam int unsigned FS_HALF = CLK_FS / 2;
  localparam int          MIN_LAT = DIV_W + 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [FREQ_W-1:0] freq_set;
  logic              set_valid;
  logic              set_ready;
  logic              clk_out;
  logic [FREQ_W-1:0] freq_act;
  logic              range_err;

  int total = 0;
  int bad   = 0;

  int   model_n;
  int   model_fa;
  int   run_len;
  int   last_high;
  int   last_low;
  logic prev_out;

  freq_gen #(
    .CLK_FS(CLK_FS),
    .FREQ_W(FREQ_W),
    .DIV_W (DIV_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .freq_set (freq_set),
    .set_valid(set_valid),
    .set_ready(set_ready),
    .clk_out  (clk_out),
    .freq_act (freq_act),
    .range_err(range_err)
  );

  // 100 MHz simulation clock; only cycle counts matter.
  always #5 sys_clk = ~sys_clk;

  // Runaway guard so the bench always ends.
  initial begin
    #950_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int clampF(input int f);
    return (f > int'(FS_HALF)) ? int'(FS_HALF) : f;
  endfunction

  function automatic int halfPeriod(input int f);
    int fc;
    fc = clampF(f);
    return (fc == 0) ? 0 : int'(CLK_FS) / (2 * fc);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge and update the run-length tracker.
  task automatic tick();
    @(negedge sys_clk);
    if (clk_out === prev_out) begin
      run_len++;
    end else begin
      if (prev_out === 1'b1) last_high = run_len;
      else                   last_low  = run_len;
      run_len  = 1;
      prev_out = clk_out;
    end
  endtask

  // Send one request and follow it through acceptance, the switch point and
  // the first few phases of the new waveform.
  task automatic applyStimulus(input int f, input bit noise);
    int   fa_new;
    int   n_new;
    int   n_old;
    int   low_cnt;
    int   bound;
    bit   clamp;
    logic lvl;
    clamp  = (f > int'(FS_HALF));
    fa_new = clampF(f);
    n_new  = halfPeriod(f);
    n_old  = model_n;

    bound = 0;
    while (set_ready !== 1'b1 && bound < 200) begin
      tick();
      bound++;
    end
    checkOutput("ready_before_req", set_ready, 1);

    freq_set  = FREQ_W'(f);
    set_valid = 1'b1;
    tick();
    set_valid = 1'b0;
    freq_set  = FREQ_W'($urandom);
    checkOutput("range_err_pulse", range_err, clamp);
    checkOutput("ready_after_accept", set_ready, 0);
    low_cnt = 1;
    if (noise) begin
      set_valid = 1'b1;
      freq_set  = FREQ_W'(7777);
    end
    tick();
    checkOutput("range_err_clear", range_err, 0);

    bound = MIN_LAT + 2 * n_old + 8;
    while (set_ready !== 1'b1 && low_cnt < bound) begin
      low_cnt++;
      checkOutput("freq_act_hold", freq_act, model_fa);
      set_valid = noise && (low_cnt < 10);
      tick();
    end
    set_valid = 1'b0;

    checkOutput("apply_in_time", set_ready, 1);
    if (n_new != 0) checkOutput("min_latency", low_cnt >= MIN_LAT, 1);
    checkOutput("freq_act_applied", freq_act, fa_new);
    checkOutput("rise_at_apply", clk_out, n_new != 0);
    if (n_old != 0) begin
      checkOutput("old_high_len", last_high, n_old);
      if (n_new != 0) checkOutput("old_low_len", last_low, n_old);
      else            checkOutput("stop_low_len", run_len, n_old + 1);
    end

    model_n  = n_new;
    model_fa = fa_new;

    if (n_new != 0) begin
      for (int ph = 0; ph < 3; ph++) begin
        lvl   = clk_out;
        bound = 0;
        while (clk_out === lvl && bound < 2 * n_new + 4) begin
          tick();
          bound++;
        end
        if (lvl === 1'b1) checkOutput("high_len", last_high, n_new);
        else              checkOutput("low_len", last_low, n_new);
      end
    end else begin
      for (int i = 0; i < 3 * n_old + 20; i++) begin
        tick();
        checkOutput("stopped_low", clk_out, 0);
      end
    end
  endtask

  // Directed sequence followed by random requests and a mid-division reset.
  initial begin
    int f;
    int bound;
    sys_rst   = 1'b1;
    set_valid = 1'b0;
    freq_set  = '0;
    prev_out  = 1'b0;
    run_len   = 0;
    last_high = 0;
    last_low  = 0;
    model_n   = 0;
    model_fa  = 0;

    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    checkOutput("rst_clk_out", clk_out, 0);
    checkOutput("rst_set_ready", set_ready, 1);
    checkOutput("rst_freq_act", freq_act, 0);
    checkOutput("rst_range_err", range_err, 0);

    for (int i = 0; i < 1000; i++) begin
      tick();
      checkOutput("idle_clk_low", clk_out, 0);
    end
    checkOutput("idle_set_ready", set_ready, 1);
    checkOutput("idle_freq_act", freq_act, 0);
    checkOutput("idle_range_err", range_err, 0);

    $display("[TB] directed requests");
    applyStimulus(500000, 1'b0);
    applyStimulus(300000, 1'b0);
    applyStimulus(1040000, 1'b0);
    applyStimulus(500000, 1'b0);
    bound = 0;
    while (clk_out !== 1'b1 && bound < 20) begin
      tick();
      bound++;
    end
    checkOutput("wait_high_phase", clk_out, 1);
    applyStimulus(int'(FS_HALF), 1'b0);
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b0);
    applyStimulus(200000, 1'b1);

    $display("[TB] random requests");
    for (int i = 0; i < 10; i++) begin
      f = int'($urandom_range(1048575, 2000));
      applyStimulus(f, 1'b0);
    end
    f = int'($urandom_range(1048575, FS_HALF + 1));
    applyStimulus(f, 1'b0);

    $display("[TB] reset during division");
    freq_set  = FREQ_W'(400000);
    set_valid = 1'b1;
    tick();
    set_valid = 1'b0;
    repeat (10) tick();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    model_n  = 0;
    model_fa = 0;
    checkOutput("abort_clk_out", clk_out, 0);
    checkOutput("abort_set_ready", set_ready, 1);
    checkOutput("abort_freq_act", freq_act, 0);
    checkOutput("abort_range_err", range_err, 0);
    for (int i = 0; i < 60; i++) begin
      tick();
      checkOutput("abort_no_apply_clk", clk_out, 0);
      checkOutput("abort_no_apply_fa", freq_act, 0);
    end
    applyStimulus(250000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
